// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register index, data word and the
// write-buffer entry carried between writeback and the register file.
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        regbits_t wsel;
        word_t    wdat;
    } wb_entry_t;

endpackage

// File: rtl/wbuf_fwd_lookup.sv
// Youngest-match search over the write-buffer entries for one read port.
// Entries are walked oldest to youngest so a later match overrides an earlier one.
module wbuf_fwd_lookup
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0]         entries,
    input  logic [DEPTH-1:0]              valid,
    input  logic [$clog2(DEPTH)-1:0]      head,
    input  logic [$clog2(DEPTH+1)-1:0]    count,
    input  regbits_t                      rsel,
    output logic                          hit,
    output word_t                         dat
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] idx;

    always_comb begin
        hit = 1'b0;
        dat = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && valid[idx] &&
                (entries[idx].wsel == rsel) && (rsel != '0)) begin
                hit = 1'b1;
                dat = entries[idx].wdat;
            end
        end
    end

endmodule

// File: rtl/rf_write_buffer.sv
// In-order write buffer between writeback and the register file: queues
// writes, drains one per cycle into the single write port, and forwards pending data.
module rf_write_buffer
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  regbits_t                      in_wsel,
    input  word_t                         in_wdat,
    input  logic                          drain_en,
    output logic                          rf_WEN,
    output regbits_t                      rf_wsel,
    output word_t                         rf_wdat,
    input  regbits_t                      fwd_rsel1,
    input  regbits_t                      fwd_rsel2,
    output logic                          fwd_hit1,
    output logic                          fwd_hit2,
    output word_t                         fwd_dat1,
    output word_t                         fwd_dat2,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t [DEPTH-1:0] mem;
    logic [DEPTH-1:0]      valid;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic                  push;
    logic                  pop;

    assign empty    = (count == '0);
    assign in_ready = (count < CW'(DEPTH));
    assign rf_WEN   = !empty && drain_en;
    assign rf_wsel  = empty ? '0 : mem[head].wsel;
    assign rf_wdat  = empty ? '0 : mem[head].wdat;

    // Writes to r0 are accepted by the handshake but never stored.
    assign push = in_valid && in_ready && (in_wsel != '0);
    assign pop  = rf_WEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; visibility is governed by valid/count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail] <= '{wsel: in_wsel, wdat: in_wdat};
        end
    end

    wbuf_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (mem),
        .valid   (valid),
        .head    (head),
        .count   (count),
        .rsel    (fwd_rsel1),
        .hit     (fwd_hit1),
        .dat     (fwd_dat1)
    );

    wbuf_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (mem),
        .valid   (valid),
        .head    (head),
        .count   (count),
        .rsel    (fwd_rsel2),
        .hit     (fwd_hit2),
        .dat     (fwd_dat2)
    );

endmodule

// File: tb/tb_rf_write_buffer.sv
// Self-checking bench for rf_write_buffer: a queue model checked every
// negedge, plus directed scenarios with hand-computed expectations.
module tb_rf_write_buffer;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        nRST;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_wsel;
    logic [31:0] in_wdat;
    logic        drain_en;
    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [4:0]  fwd_rsel1;
    logic [4:0]  fwd_rsel2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_dat1;
    logic [31:0] fwd_dat2;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    typedef struct {
        logic [4:0]  wsel;
        logic [31:0] wdat;
    } ent_t;

    ent_t q[$];

    rf_write_buffer #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wsel   (in_wsel),
        .in_wdat   (in_wdat),
        .drain_en  (drain_en),
        .rf_WEN    (rf_WEN),
        .rf_wsel   (rf_wsel),
        .rf_wdat   (rf_wdat),
        .fwd_rsel1 (fwd_rsel1),
        .fwd_rsel2 (fwd_rsel2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_dat1  (fwd_dat1),
        .fwd_dat2  (fwd_dat2),
        .count     (count),
        .empty     (empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] ws, input logic [31:0] wd,
                                 input logic de, input logic [4:0] r1, input logic [4:0] r2);
        @(posedge CLK);
        #1;
        in_valid  = v;
        in_wsel   = ws;
        in_wdat   = wd;
        drain_en  = de;
        fwd_rsel1 = r1;
        fwd_rsel2 = r2;
        #1;
    endtask

    // Model: a FIFO queue of pending writes; head pops when enabled, and
    // a new non-r0 request joins only if the queue was not full.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q.delete();
        end else begin
            int  sz;
            bit  doPush;
            sz     = q.size();
            doPush = in_valid && (sz < DEPTH) && (in_wsel != 5'd0);
            if (sz > 0 && drain_en) void'(q.pop_front());
            if (doPush) q.push_back('{wsel: in_wsel, wdat: in_wdat});
        end
    end

    function automatic void expectFwd(input logic [4:0] rsel, output logic hit, output logic [31:0] dat);
        hit = 1'b0;
        dat = 32'd0;
        if (rsel == 5'd0) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].wsel == rsel) begin
                hit = 1'b1;
                dat = q[i].wdat;
                return;
            end
        end
    endfunction

    always @(negedge CLK) begin
        if (started) begin
            logic        h1, h2;
            logic [31:0] d1, d2;
            int          sz;
            sz = q.size();
            expectFwd(fwd_rsel1, h1, d1);
            expectFwd(fwd_rsel2, h2, d2);
            checkOutput("m_count", 32'(count), 32'(sz));
            checkOutput("m_empty", 32'(empty), 32'(sz == 0));
            checkOutput("m_in_ready", 32'(in_ready), 32'(sz < DEPTH));
            checkOutput("m_rf_WEN", 32'(rf_WEN), 32'((sz > 0) && drain_en));
            checkOutput("m_rf_wsel", 32'(rf_wsel), (sz > 0) ? 32'(q[0].wsel) : 32'd0);
            checkOutput("m_rf_wdat", rf_wdat, (sz > 0) ? q[0].wdat : 32'd0);
            checkOutput("m_hit1", 32'(fwd_hit1), 32'(h1));
            checkOutput("m_dat1", fwd_dat1, d1);
            checkOutput("m_hit2", 32'(fwd_hit2), 32'(h2));
            checkOutput("m_dat2", fwd_dat2, d2);
        end
    end

    initial begin
        in_valid  = 0;
        in_wsel   = 0;
        in_wdat   = 0;
        drain_en  = 0;
        fwd_rsel1 = 0;
        fwd_rsel2 = 0;
        nRST      = 1;
        #1 nRST   = 0;
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_rf_WEN", 32'(rf_WEN), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_rf_wdat", rf_wdat, 32'd0);
        @(negedge CLK);
        #1 nRST = 1;
        started = 1;

        $display("[TB] single push and drain");
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t1_wen", 32'(rf_WEN), 32'd1);
        checkOutput("t1_wsel", 32'(rf_wsel), 32'd5);
        checkOutput("t1_wdat", rf_wdat, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t1_empty", 32'(empty), 32'd1);

        $display("[TB] fill, stall, in-order drain");
        for (int i = 1; i <= 4; i++) applyStimulus(1, 5'(i), 32'h100 + i, 0, 0, 0);
        applyStimulus(1, 5'd6, 32'h106, 0, 0, 0);
        checkOutput("t2_count_full", 32'(count), 32'd4);
        checkOutput("t2_ready_full", 32'(in_ready), 32'd0);
        checkOutput("t2_head_r1", 32'(rf_wsel), 32'd1);
        checkOutput("t2_wen_held", 32'(rf_WEN), 32'd0);
        applyStimulus(1, 5'd6, 32'h106, 0, 0, 0);
        checkOutput("t2_head_still_r1", 32'(rf_wsel), 32'd1);
        applyStimulus(1, 5'd6, 32'h106, 1, 0, 0);
        checkOutput("t2_commit_r1", 32'(rf_wsel), 32'd1);
        checkOutput("t2_commit_r1_dat", rf_wdat, 32'h101);
        applyStimulus(1, 5'd6, 32'h106, 1, 0, 0);
        checkOutput("t2_commit_r2", 32'(rf_wsel), 32'd2);
        checkOutput("t2_count3", 32'(count), 32'd3);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t2_commit_r3", 32'(rf_wsel), 32'd3);
        checkOutput("t2_count3b", 32'(count), 32'd3);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t2_commit_r4", 32'(rf_wsel), 32'd4);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t2_commit_r6", 32'(rf_wsel), 32'd6);
        checkOutput("t2_commit_r6_dat", rf_wdat, 32'h106);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t2_empty", 32'(empty), 32'd1);

        $display("[TB] forwarding youngest match");
        applyStimulus(1, 5'd7, 32'h11, 0, 5'd7, 5'd3);
        applyStimulus(1, 5'd7, 32'h22, 0, 5'd7, 5'd3);
        checkOutput("t3_dat1_old", fwd_dat1, 32'h11);
        applyStimulus(0, 0, 0, 0, 5'd7, 5'd3);
        checkOutput("t3_hit1", 32'(fwd_hit1), 32'd1);
        checkOutput("t3_dat1", fwd_dat1, 32'h22);
        checkOutput("t3_hit2", 32'(fwd_hit2), 32'd0);
        checkOutput("t3_dat2", fwd_dat2, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t3_empty", 32'(empty), 32'd1);

        $display("[TB] r0 writes discarded");
        applyStimulus(1, 5'd0, 32'hFFFF, 1, 5'd0, 5'd0);
        checkOutput("t4_ready", 32'(in_ready), 32'd1);
        applyStimulus(0, 0, 0, 1, 5'd0, 5'd0);
        checkOutput("t4_count", 32'(count), 32'd0);
        checkOutput("t4_wen", 32'(rf_WEN), 32'd0);
        checkOutput("t4_hit1", 32'(fwd_hit1), 32'd0);

        $display("[TB] sustained push/pop at full");
        for (int i = 0; i < 4; i++) applyStimulus(1, 5'(8 + i), 32'hB000_0000 + i, 0, 5'(8 + i), 5'd9);
        applyStimulus(1, 5'd12, 32'hA000_0000, 1, 5'd12, 5'd9);
        checkOutput("t5_count4", 32'(count), 32'd4);
        checkOutput("t5_wen", 32'(rf_WEN), 32'd1);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1, 5'(((12 + i - 1) % 31) + 1), 32'hA000_0000 + i, 1,
                          5'(((12 + i - 2) % 31) + 1), 5'(((12 + i - 4) % 31) + 1));
            checkOutput("t5_count3", 32'(count), 32'd3);
        end
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("t5_empty", 32'(empty), 32'd1);

        $display("[TB] reset with pending entries");
        for (int i = 0; i < 3; i++) applyStimulus(1, 5'(20 + i), 32'hC0 + i, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 5'd21, 0);
        checkOutput("t6_count3", 32'(count), 32'd3);
        applyStimulus(0, 0, 0, 1, 5'd21, 0);
        checkOutput("t6_wen_pre", 32'(rf_WEN), 32'd1);
        #1 nRST = 0;
        #1;
        checkOutput("t6_wen_rst", 32'(rf_WEN), 32'd0);
        checkOutput("t6_count_rst", 32'(count), 32'd0);
        checkOutput("t6_hit_rst", 32'(fwd_hit1), 32'd0);
        @(negedge CLK);
        #1 nRST = 1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 5'd21, 0);
            checkOutput("t6_wen_after", 32'(rf_WEN), 32'd0);
        end

        @(posedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
